// File: rtl/instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_issue_ctrl
//  Description : Pops instructions from a show-ahead FIFO and issues them to
//                the control coordinator over a valid/ready handshake, with
//                NOP discard, HALT/resume and flush-and-drain support.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_issue_ctrl #(
    parameter int         INSTR_WIDTH = 80,
    parameter logic [7:0] HALT_OPCODE = 8'hFF,
    parameter logic [7:0] NOP_OPCODE  = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] fifo_data,
    input  logic                   fifo_empty,
    output logic                   fifo_next_en,
    input  logic                   enable,
    input  logic                   resume,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   halted,
    output logic [31:0]            issued_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HALTED = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INSTR_WIDTH-1:0] r_instr_out;
    logic [31:0]            r_issued_count;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_handshake;

    logic [7:0] w_opcode;
    logic       w_head_nop;
    logic       w_head_halt;
    logic       w_head_issuable;

    assign w_opcode        = fifo_data[7:0];
    assign w_head_nop      = (w_opcode == NOP_OPCODE);
    assign w_head_halt     = (w_opcode == HALT_OPCODE);
    assign w_head_issuable = enable && !fifo_empty && !w_head_nop && !w_head_halt;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_handshake = 1'b0;
        if (flush) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        w_pop = 1'b1;
                        if (w_head_halt) begin
                            w_state_nxt = ST_HALTED;
                        end else if (!w_head_nop) begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        w_handshake = 1'b1;
                        // NOP/HALT heads are left for IDLE to consume
                        if (w_head_issuable) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_instr_out    <= '0;
            r_issued_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_instr_out <= fifo_data;
            end
            if (w_handshake) begin
                r_issued_count <= r_issued_count + 32'd1;
            end
        end
    end

    // Pop is combinational, so it must also be forced low while reset is held
    assign fifo_next_en = w_pop && !fifo_empty && rst;
    assign instr_out    = r_instr_out;
    assign instr_valid  = (r_state == ST_ISSUE);
    assign halted       = (r_state == ST_HALTED);
    assign issued_count = r_issued_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_issue_ctrl
//  Description : Randomized scoreboard bench for instr_issue_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issue_ctrl;

    localparam int W = 80;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] fifo_data;
    logic         fifo_empty;
    logic         fifo_next_en;
    logic         enable;
    logic         resume;
    logic         flush;
    logic [W-1:0] instr_out;
    logic         instr_valid;
    logic         instr_ready;
    logic         halted;
    logic [31:0]  issued_count;

    always #5 clk = ~clk;

    instr_issue_ctrl #(
        .INSTR_WIDTH (W),
        .HALT_OPCODE (8'hFF),
        .NOP_OPCODE  (8'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_next_en (fifo_next_en),
        .enable       (enable),
        .resume       (resume),
        .flush        (flush),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .halted       (halted),
        .issued_count (issued_count)
    );

    // FIFO contents and the ordered list of instructions that must come out
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int unsigned  model_count = 0;
    bit           mon_on      = 1'b0;
    bit           hold_chk    = 1'b0;
    bit           pop_seen    = 1'b0;
    bit           prev_stall  = 1'b0;
    bit           prev_flush  = 1'b0;
    logic [W-1:0] prev_out;
    bit           draining    = 1'b0;
    int           dcnt        = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic upd();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
    endtask

    task automatic push(input logic [W-1:0] d);
        fq.push_back(d);
        if (d[7:0] != 8'h00 && d[7:0] != 8'hFF) exp_q.push_back(d);
        upd();
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] op);
        logic [95:0] t;
        logic [W-1:0] d;
        t = {$urandom(), $urandom(), $urandom()};
        d = t[W-1:0];
        d[7:0] = op;
        return d;
    endfunction

    function automatic logic [7:0] rand_op();
        int r;
        r = $urandom_range(0, 19);
        if (r < 2) return 8'h00;
        if (r == 2) return 8'hFF;
        return 8'($urandom_range(1, 254));
    endfunction

    // Advance one cycle; apply the pop the DUT requested before the edge
    task automatic step();
        logic [W-1:0] tmp;
        @(posedge clk);
        #1;
        if (pop_seen && rst && fq.size() > 0) tmp = fq.pop_front();
        flush  = 1'b0;
        resume = 1'b0;
        if (draining) begin
            if (fq.size() != 0) dcnt = 2;
            else if (dcnt > 0) dcnt--;
            if (fq.size() == 0 && dcnt == 0) draining = 1'b0;
        end
        upd();
    endtask

    task automatic rand_cycle(input bit calm);
        step();
        enable      = calm ? 1'b1 : ($urandom_range(0, 9) < 8);
        instr_ready = calm ? 1'b1 : ($urandom_range(0, 9) < 7);
        resume      = halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
        if (!calm && !draining && $urandom_range(0, 49) == 0) begin
            flush    = 1'b1;
            exp_q.delete();
            draining = 1'b1;
            dcnt     = 2;
        end else if (!calm && !draining && fq.size() < 6 && $urandom_range(0, 99) < 45) begin
            push(mk(rand_op()));
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        pop_seen = fifo_next_en;
        if (!rst || !mon_on) begin
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (fifo_empty) chk("pop_when_empty", W'(fifo_next_en), '0);
            if (halted) begin
                chk("halted_pop", W'(fifo_next_en), '0);
                chk("halted_valid", W'(instr_valid), '0);
            end
            if (hold_chk) begin
                chk("disabled_pop", W'(fifo_next_en), '0);
                chk("disabled_valid", W'(instr_valid), '0);
            end
            if (prev_flush) chk("flush_valid", W'(instr_valid), '0);
            if (prev_stall) begin
                chk("stall_valid", W'(instr_valid), W'(1));
                chk("stall_data", instr_out, prev_out);
            end
            chk("issued_count", W'(issued_count), W'(model_count));
            if (instr_valid && instr_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_issue: got %h expected none", instr_out);
                end else begin
                    chk("issue_data", instr_out, exp_q.pop_front());
                end
                model_count++;
            end
            prev_stall = instr_valid && !instr_ready && !flush;
            prev_flush = flush;
            prev_out   = instr_out;
        end
    end

    initial begin
        int n;
        rst = 1'b0; enable = 1'b0; resume = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        upd();
        #12;
        chk("rst_valid", W'(instr_valid), '0);
        chk("rst_halted", W'(halted), '0);
        chk("rst_count", W'(issued_count), '0);
        chk("rst_pop", W'(fifo_next_en), '0);
        chk("rst_instr", instr_out, '0);
        step(); step();
        rst = 1'b1;
        mon_on = 1'b1;

        // enable low with a non-empty FIFO: nothing moves
        for (int i = 0; i < 3; i++) push(mk(8'(i + 1)));
        instr_ready = 1'b1;
        hold_chk = 1'b1;
        for (int i = 0; i < 5; i++) step();
        hold_chk = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // NOP, HALT, C: halts with C still queued until resume
        push(mk(8'h00)); push(mk(8'hFF)); push(mk(8'h33));
        n = 0;
        while (!halted && n < 10) begin step(); n++; end
        chk("halt_reached", W'(halted), W'(1));
        chk("halt_keeps_c", W'(fq.size()), W'(1));
        step(); resume = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // flush with an instruction pending and three behind it
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(mk(8'(8'h10 + i)));
        n = 0;
        while (!instr_valid && n < 10) begin step(); n++; end
        chk("pending_before_flush", W'(instr_valid), W'(1));
        flush = 1'b1; exp_q.delete(); draining = 1'b1; dcnt = 2;
        for (int i = 0; i < 5; i++) step();
        chk("flush_drained", W'(fq.size()), '0);

        for (int i = 0; i < 1500; i++) rand_cycle(1'b0);

        // asynchronous reset in the middle of an issue
        n = 0;
        while (draining && n < 20) begin step(); n++; end
        enable = 1'b1; instr_ready = 1'b0; resume = 1'b0;
        push(mk(8'h5A)); push(mk(8'h5B));
        n = 0;
        while (!instr_valid && n < 30) begin
            step(); n++;
            if (halted) resume = 1'b1;
        end
        chk("valid_before_reset", W'(instr_valid), W'(1));
        if (fq.size() == 0) push(mk(8'h5C));
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", W'(instr_valid), '0);
        chk("async_halted", W'(halted), '0);
        chk("async_count", W'(issued_count), '0);
        chk("async_pop", W'(fifo_next_en), '0);
        chk("async_instr", instr_out, '0);
        fq.delete(); exp_q.delete(); upd();
        model_count = 0; draining = 1'b0;
        step(); step();
        rst = 1'b1;

        for (int i = 0; i < 1500; i++) rand_cycle(1'b0);

        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || draining) && n < 400) begin
            rand_cycle(1'b1); n++;
        end
        step(); step();
        chk("final_exp_empty", W'(exp_q.size()), '0);
        chk("final_fifo_empty", W'(fq.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
